// File: rtl/srec_emitter_if.sv
// Bus bundle for srec_emitter: dump request, byte-wide memory read port and
// the ASCII character stream toward a UART transmitter.
interface srec_emitter_if;
    logic        start;
    logic [31:0] start_address;
    logic [31:0] length;
    logic [31:0] entry_address;
    logic [31:0] read_address;
    logic        read_enable;
    logic [7:0]  read_data;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, start_address, length, entry_address, read_data, char_ready,
        output read_address, read_enable, char_data, char_valid, busy, done
    );

    modport slave (
        output start, start_address, length, entry_address, read_data, char_ready,
        input  read_address, read_enable, char_data, char_valid, busy, done
    );
endinterface

// File: rtl/srec_emitter.sv
// Dumps a memory range as Motorola S-record text: S3 data records then an S7 record.
// Define SREC_EMITTER_S0_HEADER_EN to prefix the dump with the "S0030000FC" header.
module srec_emitter #(
    parameter int BYTES_PER_RECORD = 16
) (
    input logic            clock,
    input logic            reset_n,
    srec_emitter_if.master bus
);
    localparam logic [31:0] BPR32 = 32'(BYTES_PER_RECORD);
    localparam logic [7:0]  BPR8  = 8'(BYTES_PER_RECORD);

    typedef enum logic [3:0] {
        IDLE, S_CHAR, TYPE, COUNT_HI, COUNT_LO, ADDR, FETCH, FETCH_WAIT,
        DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, CR, LF, DONE
    } state_t;

    state_t      state;
    logic [31:0] addr_cur;
    logic [31:0] remaining;
    logic [31:0] entry;
    logic [31:0] rec_addr;
    logic [7:0]  rec_count;
    logic [7:0]  byte_left;
    logic [7:0]  csum;
    logic [3:0]  rec_type;
    logic [3:0]  data_lo;
    logic [2:0]  nib_idx;

    logic        xfer;
    logic [2:0]  nib_dec;
    logic [3:0]  nib_cur;
    logic [3:0]  nib_next;
    logic [7:0]  csum_n;

    logic [31:0] src_remaining;
    logic [31:0] src_addr;
    logic [31:0] src_entry;
    logic [3:0]  nxt_type;
    logic [7:0]  nxt_n;
    logic [7:0]  nxt_count;
    logic [31:0] nxt_addr;
    logic [7:0]  nxt_csum;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign xfer     = bus.char_valid & bus.char_ready;
    assign nib_dec  = nib_idx - 3'd1;
    assign nib_cur  = rec_addr[{nib_idx, 2'b00} +: 4];
    assign nib_next = rec_addr[{nib_dec, 2'b00} +: 4];
    assign csum_n   = ~csum;

    // Parameters of the record that follows: taken from the request in IDLE,
    // otherwise from the running address/remaining counters.
    always_comb begin
        src_remaining = (state == IDLE) ? bus.length        : remaining;
        src_addr      = (state == IDLE) ? bus.start_address : addr_cur;
        src_entry     = (state == IDLE) ? bus.entry_address : entry;
        nxt_n         = 8'd0;
        nxt_type      = 4'd7;
        nxt_addr      = src_entry;
        if (src_remaining != 32'd0) begin
            nxt_type = 4'd3;
            nxt_addr = src_addr;
            nxt_n    = (src_remaining < BPR32) ? src_remaining[7:0] : BPR8;
        end
        nxt_count = 8'd5 + nxt_n;
        nxt_csum  = nxt_count + nxt_addr[31:24] + nxt_addr[23:16]
                  + nxt_addr[15:8] + nxt_addr[7:0];
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state            <= IDLE;
            addr_cur         <= 32'd0;
            remaining        <= 32'd0;
            entry            <= 32'd0;
            rec_addr         <= 32'd0;
            rec_count        <= 8'd0;
            byte_left        <= 8'd0;
            csum             <= 8'd0;
            rec_type         <= 4'd0;
            data_lo          <= 4'd0;
            nib_idx          <= 3'd0;
            bus.char_valid   <= 1'b0;
            bus.char_data    <= 8'd0;
            bus.read_enable  <= 1'b0;
            bus.read_address <= 32'd0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            bus.done        <= 1'b0;
            bus.read_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_cur       <= bus.start_address;
                        remaining      <= bus.length;
                        entry          <= bus.entry_address;
                        bus.busy       <= 1'b1;
                        bus.char_valid <= 1'b1;
                        bus.char_data  <= 8'h53;
                        state          <= S_CHAR;
`ifdef SREC_EMITTER_S0_HEADER_EN
                        rec_type  <= 4'd0;
                        rec_count <= 8'h03;
                        rec_addr  <= 32'd0;
                        byte_left <= 8'd0;
                        csum      <= 8'h03;
                        nib_idx   <= 3'd3;
`else
                        rec_type  <= nxt_type;
                        rec_count <= nxt_count;
                        rec_addr  <= nxt_addr;
                        byte_left <= nxt_n;
                        csum      <= nxt_csum;
                        nib_idx   <= 3'd7;
`endif
                    end
                end
                S_CHAR: if (xfer) begin
                    bus.char_data <= hex_char(rec_type);
                    state         <= TYPE;
                end
                TYPE: if (xfer) begin
                    bus.char_data <= hex_char(rec_count[7:4]);
                    state         <= COUNT_HI;
                end
                COUNT_HI: if (xfer) begin
                    bus.char_data <= hex_char(rec_count[3:0]);
                    state         <= COUNT_LO;
                end
                COUNT_LO: if (xfer) begin
                    bus.char_data <= hex_char(nib_cur);
                    state         <= ADDR;
                end
                ADDR: if (xfer) begin
                    if (nib_idx != 3'd0) begin
                        nib_idx       <= nib_dec;
                        bus.char_data <= hex_char(nib_next);
                    end else if (byte_left != 8'd0) begin
                        bus.char_valid   <= 1'b0;
                        bus.read_enable  <= 1'b1;
                        bus.read_address <= addr_cur;
                        state            <= FETCH;
                    end else begin
                        bus.char_data <= hex_char(csum_n[7:4]);
                        state         <= CSUM_HI;
                    end
                end
                FETCH: begin
                    addr_cur  <= addr_cur + 32'd1;
                    remaining <= remaining - 32'd1;
                    byte_left <= byte_left - 8'd1;
                    state     <= FETCH_WAIT;
                end
                // read_data belongs to the strobe issued in FETCH
                FETCH_WAIT: begin
                    data_lo        <= bus.read_data[3:0];
                    csum           <= csum + bus.read_data;
                    bus.char_valid <= 1'b1;
                    bus.char_data  <= hex_char(bus.read_data[7:4]);
                    state          <= DATA_HI;
                end
                DATA_HI: if (xfer) begin
                    bus.char_data <= hex_char(data_lo);
                    state         <= DATA_LO;
                end
                DATA_LO: if (xfer) begin
                    if (byte_left != 8'd0) begin
                        bus.char_valid   <= 1'b0;
                        bus.read_enable  <= 1'b1;
                        bus.read_address <= addr_cur;
                        state            <= FETCH;
                    end else begin
                        bus.char_data <= hex_char(csum_n[7:4]);
                        state         <= CSUM_HI;
                    end
                end
                CSUM_HI: if (xfer) begin
                    bus.char_data <= hex_char(csum_n[3:0]);
                    state         <= CSUM_LO;
                end
                CSUM_LO: if (xfer) begin
                    bus.char_data <= 8'h0D;
                    state         <= CR;
                end
                CR: if (xfer) begin
                    bus.char_data <= 8'h0A;
                    state         <= LF;
                end
                LF: if (xfer) begin
                    if (rec_type == 4'd7) begin
                        bus.char_valid <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        rec_type      <= nxt_type;
                        rec_count     <= nxt_count;
                        rec_addr      <= nxt_addr;
                        byte_left     <= nxt_n;
                        csum          <= nxt_csum;
                        nib_idx       <= 3'd7;
                        bus.char_data <= 8'h53;
                        state         <= S_CHAR;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
